alu_arbiter: RTL and testbench

Shares the single combinational integer ALU between two requesters: port 0, the pipeline EX stage, and port 1, the secondary unit (address/CSR helper). It grants one operation per cycle, drives the ALU operand and control inputs, and captures the result and zero flag in a one-entry response buffer. The buffer is tagged with the owning port and is released through a per-port valid/ready handshake.

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared combinational ALU, with a one-entry
// result buffer tagged by owning port and released per port via valid/ready.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  input  logic        flush0,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_datain1,
  output logic [31:0] alu_datain2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  logic        full_q, full_d;
  logic        owner_q, owner_d;
  logic        zero_q, zero_d;
  logic        last_q, last_d;
  logic [31:0] result_q, result_d;

  logic drain, flush_clr, can_accept, v0, v1, gnt0, gnt1;

  always_comb begin
    drain      = full_q & (owner_q ? rsp1_ready : rsp0_ready);
    flush_clr  = full_q & ~owner_q & flush0;
    can_accept = ~full_q | drain | flush_clr;
    v0         = req0_valid & ~flush0;
    v1         = req1_valid;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    // rst_n gating keeps both readies low while reset is held
    if (can_accept && rst_n) begin
      if (v0 && v1) begin
        if (FIXED_PRIO || last_q) gnt0 = 1'b1;
        else                      gnt1 = 1'b1;
      end else begin
        gnt0 = v0;
        gnt1 = v1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Idle cycles park the ALU on port 0's fields.
  always_comb begin
    alu_ctrl    = gnt1 ? req1_ctrl : req0_ctrl;
    alu_datain1 = gnt1 ? req1_op1  : req0_op1;
    alu_datain2 = gnt1 ? req1_op2  : req0_op2;
  end

  always_comb begin
    full_d   = full_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
    last_d   = last_q;
    if (gnt0 || gnt1) begin
      full_d   = 1'b1;
      owner_d  = gnt1;
      result_d = alu_result;
      zero_d   = alu_zero;
      last_d   = gnt1;
    end else if (drain || flush_clr) begin
      full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      full_q   <= full_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      last_q   <= last_d;
    end
  end

  assign rsp0_valid = full_q & ~owner_q;
  assign rsp1_valid = full_q &  owner_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expected responses,
// a negedge monitor checks every presented response against the queue head.
module tb_alu_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1, flush0 = 1'b0;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero;
  logic [31:0] rsp_result;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_datain1, alu_datain2, alu_result;
  logic        alu_zero;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_rsp_zero;
  logic [31:0] fp_rsp_result;
  logic [3:0]  fp_alu_ctrl;
  logic [31:0] fp_alu_datain1, fp_alu_datain2, fp_alu_result;
  logic        fp_alu_zero;

  int   nchk = 0;
  int   nerr = 0;
  bit   chk_fp = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  // ALU model: 1 = SUB, 2 = AND, else ADD
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd1:    return a - b;
      4'd2:    return a & b;
      default: return a + b;
    endcase
  endfunction

  always_comb begin
    alu_result    = alu_f(alu_ctrl, alu_datain1, alu_datain2);
    alu_zero      = (alu_result == 32'd0);
    fp_alu_result = alu_f(fp_alu_ctrl, fp_alu_datain1, fp_alu_datain2);
    fp_alu_zero   = (fp_alu_result == 32'd0);
  end

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .flush0(flush0),
    .alu_ctrl(alu_ctrl), .alu_datain1(alu_datain1), .alu_datain2(alu_datain2),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctrl(req0_ctrl),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctrl(req1_ctrl),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .flush0(flush0),
    .alu_ctrl(fp_alu_ctrl), .alu_datain1(fp_alu_datain1), .alu_datain2(fp_alu_datain2),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_ctrl = c; req0_op1 = a; req0_op2 = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_ctrl = c; req1_op1 = a; req1_op2 = b;
  endtask

  // Called at posedge+1 after inputs are set; checks grants, queues the
  // expected response, and returns at the next posedge+1.
  task automatic tick(input logic er0, input logic er1, input logic [31:0] eres, input logic ez,
                      input logic fr0, input logic fr1);
    #3;
    check("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
    if (chk_fp) begin
      check("fp_req0_ready", {31'd0, fp_req0_ready}, {31'd0, fr0});
      check("fp_req1_ready", {31'd0, fp_req1_ready}, {31'd0, fr1});
    end
    if (er0) q.push_back('{port: 1'b0, res: eres, z: ez});
    if (er1) q.push_back('{port: 1'b1, res: eres, z: ez});
    @(posedge clk); #1;
  endtask

  // Monitor: any presented response must match the head of the queue;
  // it pops on handshake or when flush0 kills a port-0 response.
  always @(negedge clk) begin
    if (rsp0_valid && rsp1_valid) begin
      nchk++; nerr++;
      $display("FAIL rsp_both_valid: got 1 expected 0");
    end else if (rsp0_valid || rsp1_valid) begin
      nchk++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL rsp_spurious: port %0d result %0h with empty scoreboard", rsp1_valid, rsp_result);
      end else if (q[0].port !== rsp1_valid || q[0].res !== rsp_result || q[0].z !== rsp_zero) begin
        nerr++;
        $display("FAIL rsp_data: got port %0d res %0h z %0d expected port %0d res %0h z %0d",
                 rsp1_valid, rsp_result, rsp_zero, q[0].port, q[0].res, q[0].z);
      end
      if (q.size() != 0) begin
        if (rsp0_valid && (flush0 || rsp0_ready)) void'(q.pop_front());
        else if (rsp1_valid && rsp1_ready)        void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with a request already pending
    req0_valid = 1'b1;
    #2;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // single op and zero flag
    chk_fp = 1'b1;
    set0(1, 4'd0, 32'd5, 32'd7);  tick(1, 0, 32'd12, 0, 1, 0);
    set0(0, 4'd0, 32'd0, 32'd0);  tick(0, 0, 32'd0, 0, 0, 0);
    set1(1, 4'd1, 32'd9, 32'd9);  tick(0, 1, 32'd0, 1, 0, 1);
    set1(0, 4'd0, 32'd0, 32'd0);  tick(0, 0, 32'd0, 0, 0, 0);

    // round-robin conflict; fixed-priority instance starves port 1
    set0(1, 4'd0, 32'd1, 32'd2);    set1(1, 4'd0, 32'd100, 32'd1); tick(1, 0, 32'd3, 0, 1, 0);
    set0(1, 4'd0, 32'd10, 32'd20);                                 tick(0, 1, 32'd101, 0, 1, 0);
    set1(1, 4'd0, 32'd200, 32'd2);                                 tick(1, 0, 32'd30, 0, 1, 0);
    set0(1, 4'd0, 32'd4, 32'd4);                                   tick(0, 1, 32'd202, 0, 1, 0);
    set1(0, 4'd0, 32'd0, 32'd0);                                   tick(1, 0, 32'd8, 0, 1, 0);
    set0(0, 4'd0, 32'd0, 32'd0);                                   tick(0, 0, 32'd0, 0, 0, 0);
    chk_fp = 1'b0;

    // back-pressure, then drain and grant in the same cycle
    rsp0_ready = 1'b0;
    set0(1, 4'd0, 32'd2, 32'd3);  tick(1, 0, 32'd5, 0, 0, 0);
    set0(1, 4'd0, 32'd6, 32'd6);  set1(1, 4'd0, 32'd1, 32'd1);
    repeat (3) tick(0, 0, 32'd0, 0, 0, 0);
    rsp0_ready = 1'b1;            tick(0, 1, 32'd2, 0, 0, 0);
    set1(0, 4'd0, 32'd0, 32'd0);  tick(1, 0, 32'd12, 0, 0, 0);
    set0(0, 4'd0, 32'd0, 32'd0);  tick(0, 0, 32'd0, 0, 0, 0);

    // flush of a buffered port-0 result with port 1 refilling
    rsp0_ready = 1'b0;
    set0(1, 4'd0, 32'd7, 32'd8);  tick(1, 0, 32'd15, 0, 0, 0);
    flush0 = 1'b1;
    set0(1, 4'd0, 32'd9, 32'd9);  set1(1, 4'd1, 32'd50, 32'd8);   tick(0, 1, 32'd42, 0, 0, 0);
    flush0 = 1'b0;
    set0(0, 4'd0, 32'd0, 32'd0);  set1(0, 4'd0, 32'd0, 32'd0);    tick(0, 0, 32'd0, 0, 0, 0);
    // flush suppresses a lone port-0 request
    flush0 = 1'b1;
    set0(1, 4'd2, 32'hF0F0, 32'h0FF0); tick(0, 0, 32'd0, 0, 0, 0);
    flush0 = 1'b0;                     tick(1, 0, 32'h00F0, 0, 0, 0);
    rsp0_ready = 1'b1;
    set0(0, 4'd0, 32'd0, 32'd0);       tick(0, 0, 32'd0, 0, 0, 0);

    // asynchronous reset with a full buffer
    rsp0_ready = 1'b0;
    set0(1, 4'd0, 32'd3, 32'd3);  tick(1, 0, 32'd6, 0, 0, 0);
    set0(0, 4'd0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("async_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set0(1, 4'd0, 32'd1, 32'd2);  set1(1, 4'd0, 32'd5, 32'd5);    tick(1, 0, 32'd3, 0, 0, 0);
    set0(0, 4'd0, 32'd0, 32'd0);                                   tick(0, 1, 32'd10, 0, 0, 0);
    set1(0, 4'd0, 32'd0, 32'd0);                                   tick(0, 0, 32'd0, 0, 0, 0);
    tick(0, 0, 32'd0, 0, 0, 0);

    check("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
